// File: rtl/ps2kb_scancode_controller.sv
// PS/2 keyboard scancode sequencer: folds E0/F0 prefixes into make/break events, queues them
// for a valid/ready consumer and drives the PS/2 clock-inhibit after errors or while the queue is full.
module ps2kb_scancode_controller #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter logic [15:0] INHIBIT_CYCLES = 16'd2000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_received,
  input  logic       rx_error,
  output logic       device_clock_inhibit,
  output logic       event_valid,
  input  logic       event_ready,
  output logic [9:0] event_data,
  output logic       bat_ok,
  output logic       overrun
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {RUN, INH_ERR, INH_FULL} state_t;

  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          ext_q, ext_d;
  logic          brk_q, brk_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          inh_q;
  logic          bat_q, bat_d;
  logic          ovr_q, ovr_d;
  logic [9:0]    mem [FIFO_DEPTH];

  logic          pop;
  logic          want_push;
  logic          push_en;
  logic [9:0]    push_data;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ext_d     = ext_q;
    brk_d     = brk_q;
    bat_d     = 1'b0;
    ovr_d     = 1'b0;
    want_push = 1'b0;
    push_en   = 1'b0;
    push_data = {brk_q, ext_q, rx_data};
    pop       = (count_q != '0) && event_ready;

    if (rx_error) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (rx_received && (state_q != INH_ERR)) begin
      case (rx_data)
        8'hE0: ext_d = 1'b1;
        8'hF0: brk_d = 1'b1;
        8'h00, 8'hFF: begin
          ovr_d = 1'b1;
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
        8'hAA: begin
          if (!ext_q && !brk_q) bat_d = 1'b1;
          else                  want_push = 1'b1;
        end
        default: want_push = 1'b1;
      endcase
    end

    // A push into a full queue only succeeds if the head leaves in the same cycle.
    if (want_push) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
      if ((count_q == FULL_CNT) && !pop) ovr_d   = 1'b1;
      else                               push_en = 1'b1;
    end

    wr_ptr_d = push_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push_en, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      RUN: begin
        if (rx_error) begin
          state_d = INH_ERR;
          cnt_d   = '0;
        end else if (count_d == FULL_CNT) begin
          state_d = INH_FULL;
        end
      end
      INH_ERR: begin
        if (rx_error) begin
          cnt_d = '0;
        end else if (cnt_q == INHIBIT_CYCLES - 16'd1) begin
          cnt_d   = '0;
          state_d = (count_d == FULL_CNT) ? INH_FULL : RUN;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      INH_FULL: begin
        if (rx_error) begin
          state_d = INH_ERR;
          cnt_d   = '0;
        end else if (count_d != FULL_CNT) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      inh_q    <= 1'b0;
      bat_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ext_q    <= ext_d;
      brk_q    <= brk_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      inh_q    <= (state_d != RUN);
      bat_q    <= bat_d;
      ovr_q    <= ovr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_en) mem[wr_ptr_q] <= push_data;
  end

  assign device_clock_inhibit = inh_q;
  assign event_valid          = (count_q != '0);
  assign event_data           = event_valid ? mem[rd_ptr_q] : 10'h000;
  assign bat_ok               = bat_q;
  assign overrun              = ovr_q;

endmodule

// File: tb/tb_ps2kb_scancode_controller.sv
// Bench for ps2kb_scancode_controller: directed scenarios then random traffic, all
// compared each cycle against a queue-based behavioural model.
module tb_ps2kb_scancode_controller;

  localparam int DEPTH = 4;
  localparam int IC    = 24;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_received;
  logic       rx_error;
  logic       device_clock_inhibit;
  logic       event_valid;
  logic       event_ready;
  logic [9:0] event_data;
  logic       bat_ok;
  logic       overrun;

  always #5 clock = ~clock;

  ps2kb_scancode_controller #(
    .FIFO_DEPTH    (DEPTH),
    .INHIBIT_CYCLES(16'(IC))
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .rx_data             (rx_data),
    .rx_received         (rx_received),
    .rx_error            (rx_error),
    .device_clock_inhibit(device_clock_inhibit),
    .event_valid         (event_valid),
    .event_ready         (event_ready),
    .event_data          (event_data),
    .bat_ok              (bat_ok),
    .overrun             (overrun)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: pending prefixes, event queue, remaining error-inhibit cycles.
  logic [9:0] mq[$];
  bit         m_ext, m_brk;
  int         err_left;
  bit         e_bat, e_ovr;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  task automatic step(input bit rst, input logic [7:0] d, input bit rv, input bit er, input bit rd);
    int sz;
    bit pop;
    reset       = rst;
    rx_data     = d;
    rx_received = rv;
    rx_error    = er;
    event_ready = rd;
    if (rst) begin
      mq.delete();
      m_ext = 0; m_brk = 0; err_left = 0; e_bat = 0; e_ovr = 0;
    end else begin
      sz    = mq.size();
      pop   = (sz > 0) && rd;
      e_bat = 0;
      e_ovr = 0;
      if (pop) void'(mq.pop_front());
      if (er) begin
        err_left = IC;
        m_ext = 0; m_brk = 0;
      end else if (err_left > 0) begin
        err_left--;
      end else if (rv) begin
        if (d == 8'hE0) m_ext = 1;
        else if (d == 8'hF0) m_brk = 1;
        else if (d == 8'h00 || d == 8'hFF) begin
          e_ovr = 1; m_ext = 0; m_brk = 0;
        end else if (d == 8'hAA && !m_ext && !m_brk) begin
          e_bat = 1;
        end else begin
          if (sz == DEPTH && !pop) e_ovr = 1;
          else mq.push_back({m_brk, m_ext, d});
          m_ext = 0; m_brk = 0;
        end
      end
    end
    @(posedge clock);
    @(negedge clock);
    cyc++;
    check("inhibit", 32'(device_clock_inhibit), 32'((err_left > 0) || (mq.size() == DEPTH)));
    check("valid",   32'(event_valid),          32'(mq.size() > 0));
    check("data",    32'(event_data),           (mq.size() > 0) ? 32'(mq[0]) : 32'h0);
    check("bat_ok",  32'(bat_ok),               32'(e_bat));
    check("overrun", 32'(overrun),              32'(e_ovr));
  endtask

  task automatic idle(input int n, input bit rd);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0, rd);
  endtask

  task automatic byte_in(input logic [7:0] b, input bit rd);
    step(0, b, 1, 0, rd);
    idle(2, rd);
  endtask

  initial begin
    int inh_len;
    reset = 1'b1; rx_data = '0; rx_received = 0; rx_error = 0; event_ready = 0;
    @(negedge clock);
    step(1, 8'h00, 0, 0, 0);
    step(1, 8'h00, 0, 0, 0);
    idle(2, 0);

    // Single make code, then pop it
    byte_in(8'h1C, 0);
    idle(1, 1);

    // Extended break
    byte_in(8'hE0, 1);
    byte_in(8'hF0, 1);
    byte_in(8'h75, 1);

    // Error mid-sequence; measure inhibit length independently
    step(0, 8'hE0, 1, 0, 1);
    step(0, 8'h00, 0, 1, 1);
    inh_len = 1;
    for (int i = 0; i < IC + 5; i++) begin
      if (device_clock_inhibit !== 1'b1) break;
      step(0, 8'h00, 0, 0, 1);
      if (device_clock_inhibit === 1'b1) inh_len++;
    end
    check("inh_len", 32'(inh_len), 32'(IC));
    byte_in(8'h1C, 1);

    // Overflow with consumer stalled, then one pop, then drain
    for (int k = 1; k <= 5; k++) byte_in(8'(k), 0);
    idle(1, 1);
    idle(2, 0);
    idle(6, 1);

    // BAT and keyboard overrun codes
    byte_in(8'hAA, 1);
    byte_in(8'hFF, 1);
    byte_in(8'hE0, 1);
    byte_in(8'hAA, 1);

    // Reset while inhibited with queued events
    byte_in(8'h11, 0);
    byte_in(8'h22, 0);
    step(0, 8'h00, 0, 1, 0);
    idle(3, 0);
    step(1, 8'h00, 0, 0, 0);
    idle(3, 0);

    // Random traffic
    for (int i = 0; i < 5000; i++) begin
      logic [7:0] b;
      bit rv, er, rd, rs;
      case ($urandom_range(0, 7))
        0: b = 8'hE0;
        1: b = 8'hF0;
        2: b = 8'hAA;
        3: b = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'hFF;
        default: b = 8'($urandom_range(0, 255));
      endcase
      rv = ($urandom_range(0, 2) == 0);
      er = ($urandom_range(0, 79) == 0);
      rd = ((i / 64) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
      rs = ($urandom_range(0, 999) == 0);
      step(rs, b, rv, er, rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
